// File: rtl/fpu_sc_pkg.sv
// Shared types and constants for the FPU special-case detector.
package fpu_sc_pkg;

   // Exponent field widths for the two supported operand formats.
   localparam int EXP_W_32 = 8;
   localparam int EXP_W_64 = 11;

   // Special-case outcome codes consumed by select_result.
   typedef enum logic [2:0] {
      EXC_NONE    = 3'd0,
      EXC_INVALID = 3'd1,
      EXC_COPY_A  = 3'd2,
      EXC_COPY_B  = 3'd3,
      EXC_INF     = 3'd4,
      EXC_ZERO    = 3'd5,
      EXC_DIV0    = 3'd6
   } exc_code_e;

   // Operand classes.
   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } fpu_op_e;

   // Exponent width for a given operand width.
   function automatic int exp_w_for(input int width);
      return (width == 64) ? EXP_W_64 : EXP_W_32;
   endfunction

endpackage

// File: rtl/fpu_special_case_detect_classify.sv
// Combinational IEEE-754 operand classifier; works on the magnitude only.
module fp_classify
   import fpu_sc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = WIDTH - EXP_W - 1
) (
   input  logic [WIDTH-2:0] magnitude,
   output fp_class_e        cls
);

   logic [EXP_W-1:0] exp_field;
   logic [MAN_W-1:0] man_field;

   assign exp_field = magnitude[WIDTH-2 -: EXP_W];
   assign man_field = magnitude[MAN_W-1:0];

   // Decode the class from the exponent and mantissa fields.
   always_comb begin
      if (exp_field == '0) begin
         cls = (man_field == '0) ? CLS_ZERO : CLS_SUB;
      end else if (&exp_field) begin
         if (man_field == '0)         cls = CLS_INF;
         else if (man_field[MAN_W-1]) cls = CLS_QNAN;
         else                         cls = CLS_SNAN;
      end else begin
         cls = CLS_NORM;
      end
   end

endmodule

// File: rtl/fpu_special_case_detect.sv
// Two-stage operand classifier resolving the special-case code for select_result.
module fpu_special_case_detect
   import fpu_sc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int EXP_W = exp_w_for(WIDTH),
   parameter int MAN_W = WIDTH - EXP_W - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       exception_flag,
   output logic             sign_a,
   output logic             sign_b,
   output logic [WIDTH-2:0] copied_operand,
   input  logic             clr_flags,
   output logic             flag_invalid,
   output logic             flag_divzero
);

   // Mantissa MSB position within the sign-less operand; OR-ing it in quiets a NaN.
   localparam logic [WIDTH-2:0] QUIET_BIT = {{EXP_W{1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   fpu_op_e          s1_op;
   fp_class_e        s1_cls_a;
   fp_class_e        s1_cls_b;
   fp_class_e        cls_a;
   fp_class_e        cls_b;
   logic             s2_ready;
   logic             eff_sign_b;
   exc_code_e        code_d;
   logic [WIDTH-2:0] copied_d;

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;

   fp_classify #(.WIDTH(WIDTH), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .magnitude (a[WIDTH-2:0]),
      .cls       (cls_a)
   );

   fp_classify #(.WIDTH(WIDTH), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .magnitude (b[WIDTH-2:0]),
      .cls       (cls_b)
   );

   // Stage 1 occupancy: refills or empties whenever it may advance.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (rst)           s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
   end

   // Stage 1 payload capture on an accepted beat.
   always_ff @(posedge clk) begin
      // NOTE: payload registers are left unreset; s1_valid alone decides whether they mean anything.
      if (in_valid && in_ready) begin
         s1_a     <= a;
         s1_b     <= b;
         s1_op    <= fpu_op_e'(op);
         s1_cls_a <= cls_a;
         s1_cls_b <= cls_b;
      end
   end

   assign eff_sign_b = s1_b[WIDTH-1] ^ (s1_op == OP_SUB);

   // Resolve the special-case code; priority follows the if/else order.
   always_comb begin
      // NOTE: default first so every path assigns code_d and no latch is inferred.
      code_d = EXC_NONE;
      if (s1_cls_a == CLS_SNAN || s1_cls_b == CLS_SNAN) begin
         code_d = EXC_INVALID;
      end else if (s1_cls_a == CLS_QNAN) begin
         code_d = EXC_COPY_A;
      end else if (s1_cls_b == CLS_QNAN) begin
         code_d = EXC_COPY_B;
      end else begin
         case (s1_op)
            OP_ADD, OP_SUB: begin
               if (s1_cls_a == CLS_INF && s1_cls_b == CLS_INF && (s1_a[WIDTH-1] != eff_sign_b))
                  code_d = EXC_INVALID;
               else if (s1_cls_a == CLS_INF) code_d = EXC_COPY_A;
               else if (s1_cls_b == CLS_INF) code_d = EXC_COPY_B;
            end
            OP_MUL: begin
               if ((s1_cls_a == CLS_ZERO && s1_cls_b == CLS_INF) ||
                   (s1_cls_a == CLS_INF  && s1_cls_b == CLS_ZERO))
                  code_d = EXC_INVALID;
               else if (s1_cls_a == CLS_INF  || s1_cls_b == CLS_INF)  code_d = EXC_INF;
               else if (s1_cls_a == CLS_ZERO || s1_cls_b == CLS_ZERO) code_d = EXC_ZERO;
            end
            default: begin // OP_DIV
               if ((s1_cls_a == CLS_ZERO && s1_cls_b == CLS_ZERO) ||
                   (s1_cls_a == CLS_INF  && s1_cls_b == CLS_INF))
                  code_d = EXC_INVALID;
               else if (s1_cls_a == CLS_INF)  code_d = EXC_INF;
               else if (s1_cls_b == CLS_INF)  code_d = EXC_ZERO;
               else if (s1_cls_b == CLS_ZERO) code_d = EXC_DIV0;
               else if (s1_cls_a == CLS_ZERO) code_d = EXC_ZERO;
            end
         endcase
      end
   end

   // Pass-through operand (quieted) for the copy codes, zero otherwise.
   always_comb begin
      copied_d = '0;
      if (code_d == EXC_COPY_A)      copied_d = s1_a[WIDTH-2:0] | QUIET_BIT;
      else if (code_d == EXC_COPY_B) copied_d = s1_b[WIDTH-2:0] | QUIET_BIT;
   end

   // Stage 2 output register; holds while stalled by out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         exception_flag <= EXC_NONE;
         sign_a         <= 1'b0;
         sign_b         <= 1'b0;
         copied_operand <= '0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            exception_flag <= code_d;
            sign_a         <= s1_a[WIDTH-1];
            sign_b         <= eff_sign_b;
            copied_operand <= copied_d;
         end
      end
   end

   // Sticky status flags: set by a delivered beat, cleared on request, set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_invalid <= 1'b0;
         flag_divzero <= 1'b0;
      end else begin
         if (out_valid && out_ready && exception_flag == EXC_INVALID) flag_invalid <= 1'b1;
         else if (clr_flags)                                          flag_invalid <= 1'b0;
         if (out_valid && out_ready && exception_flag == EXC_DIV0)    flag_divzero <= 1'b1;
         else if (clr_flags)                                          flag_divzero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpu_special_case_detect.sv
// Randomized and directed bench for fpu_special_case_detect (WIDTH=32).
module tb_fpu_special_case_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  exception_flag;
   logic        sign_a;
   logic        sign_b;
   logic [30:0] copied_operand;
   logic        clr_flags;
   logic        flag_invalid;
   logic        flag_divzero;

   fpu_special_case_detect #(.WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .op             (op),
      .a              (a),
      .b              (b),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .exception_flag (exception_flag),
      .sign_a         (sign_a),
      .sign_b         (sign_b),
      .copied_operand (copied_operand),
      .clr_flags      (clr_flags),
      .flag_invalid   (flag_invalid),
      .flag_divzero   (flag_divzero)
   );

   always #5 clk = ~clk;

   // Reference classes and codes, written straight from the IEEE rules.
   localparam int K_ZERO = 0, K_SUB = 1, K_NORM = 2, K_INF = 3, K_QNAN = 4, K_SNAN = 5;
   localparam int R_NONE = 0, R_INVALID = 1, R_COPY_A = 2, R_COPY_B = 3, R_INF = 4, R_ZERO = 5, R_DIV0 = 6;

   typedef struct {
      int          code;
      logic        sa;
      logic        sb;
      logic [30:0] copied;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          m_inv = 1'b0;
   bit          m_dz  = 1'b0;
   bit          last_accept;
   int          n_out = 0;
   logic [2:0]  last_code;
   logic [30:0] last_copied;
   logic        last_sb;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic int class_of(input logic [31:0] x);
      int e = int'((x >> 23) & 32'hFF);
      int m = int'(x & 32'h7FFFFF);
      if (e == 0)   return (m == 0) ? K_ZERO : K_SUB;
      if (e == 255) begin
         if (m == 0) return K_INF;
         return (m >= 32'h400000) ? K_QNAN : K_SNAN;
      end
      return K_NORM;
   endfunction

   function automatic exp_t model(input int opc, input logic [31:0] x, input logic [31:0] y);
      exp_t r;
      int   ca = class_of(x);
      int   cb = class_of(y);
      bit   sx = x[31];
      bit   sy = y[31] ^ (opc == 1);
      bit   fin_nz_a = (ca == K_SUB || ca == K_NORM);
      r.sa = sx;
      r.sb = sy;
      r.code = R_NONE;
      if (ca == K_SNAN || cb == K_SNAN) r.code = R_INVALID;
      else if (ca == K_QNAN)            r.code = R_COPY_A;
      else if (cb == K_QNAN)            r.code = R_COPY_B;
      else if (opc <= 1) begin
         if (ca == K_INF && cb == K_INF && sx != sy) r.code = R_INVALID;
         else if (ca == K_INF)                       r.code = R_COPY_A;
         else if (cb == K_INF)                       r.code = R_COPY_B;
      end else if (opc == 2) begin
         if ((ca == K_ZERO && cb == K_INF) || (ca == K_INF && cb == K_ZERO)) r.code = R_INVALID;
         else if (ca == K_INF || cb == K_INF)                                r.code = R_INF;
         else if (ca == K_ZERO || cb == K_ZERO)                              r.code = R_ZERO;
      end else begin
         if ((ca == K_ZERO && cb == K_ZERO) || (ca == K_INF && cb == K_INF)) r.code = R_INVALID;
         else if (ca == K_INF)                                               r.code = R_INF;
         else if (cb == K_INF)                                               r.code = R_ZERO;
         else if (cb == K_ZERO && fin_nz_a)                                  r.code = R_DIV0;
         else if (ca == K_ZERO)                                              r.code = R_ZERO;
      end
      if (r.code == R_COPY_A)      r.copied = 31'((x & 32'h7FFFFFFF) | 32'h00400000);
      else if (r.code == R_COPY_B) r.copied = 31'((y & 32'h7FFFFFFF) | 32'h00400000);
      else                         r.copied = '0;
      return r;
   endfunction

   // One clock: called just after a falling edge with inputs already driven.
   task automatic tick();
      exp_t e;
      bit   set_i = 1'b0;
      bit   set_d = 1'b0;
      #1;
      last_accept = 1'b0;
      if (rst) begin
         sb_q.delete();
         m_inv = 1'b0;
         m_dz  = 1'b0;
      end else begin
         check("flag_invalid", flag_invalid, m_inv);
         check("flag_divzero", flag_divzero, m_dz);
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               check("spurious_out", out_valid, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("exception_flag", exception_flag, e.code);
               check("sign_a", sign_a, e.sa);
               check("sign_b", sign_b, e.sb);
               check("copied_operand", copied_operand, e.copied);
               set_i = (e.code == R_INVALID);
               set_d = (e.code == R_DIV0);
               last_code   = exception_flag;
               last_copied = copied_operand;
               last_sb     = sign_b;
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(int'(op), a, b));
            last_accept = 1'b1;
         end
         m_inv = set_i ? 1'b1 : (clr_flags ? 1'b0 : m_inv);
         m_dz  = set_d ? 1'b1 : (clr_flags ? 1'b0 : m_dz);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int budget = 50;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((sb_q.size() != 0 || out_valid) && budget > 0) begin
         tick();
         budget--;
      end
      check("drain_left", sb_q.size(), 0);
   endtask

   task automatic directed(input int opc, input logic [31:0] x, input logic [31:0] y,
                           input int want_code, input logic [30:0] want_copied, input string tag);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = opc[1:0]; a = x; b = y;
      tick();
      drain();
      check({tag, "_code"}, last_code, want_code);
      check({tag, "_copied"}, last_copied, want_copied);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                     32'h7FC0_0000, 32'h7FA0_0000, 32'hFFC0_0001, 32'h0000_0001,
                                     32'h3F80_0000, 32'h7F80_0001};
      if ($urandom_range(3) != 0) return specials[$urandom_range(9)];
      return $urandom;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [31:0] bp_a [4] = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0123};
   logic [31:0] bp_b [4] = '{32'h0000_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h4000_0000};
   logic [1:0]  bp_op[4] = '{2'd3, 2'd0, 2'd2, 2'd1};

   initial begin
      int k;
      int out_before;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      op = '0; a = '0; b = '0;
      @(negedge clk);
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_exception_flag", exception_flag, 3'd0);
      check("rst_sign_a", sign_a, 1'b0);
      check("rst_sign_b", sign_b, 1'b0);
      check("rst_copied", copied_operand, 31'd0);
      check("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // Directed cases.
      directed(0, 32'h7F80_0000, 32'hFF80_0000, R_INVALID, 31'd0, "add_inf_ninf");
      check("add_inf_flag_invalid", flag_invalid, 1'b1);
      directed(3, 32'h3F80_0000, 32'h0000_0000, R_DIV0, 31'd0, "div_by_zero");
      check("div0_flag_divzero", flag_divzero, 1'b1);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      check("clr_flag_divzero", flag_divzero, 1'b0);
      check("clr_flag_invalid", flag_invalid, 1'b0);
      directed(2, 32'h7FA0_0000, 32'h7FC0_0000, R_INVALID, 31'd0, "mul_snan");
      directed(2, 32'h3F80_0000, 32'h7FC0_0001, R_COPY_B, 31'h7FC0_0001, "mul_qnan_b");
      directed(1, 32'h7F80_0000, 32'h7F80_0000, R_INVALID, 31'd0, "sub_inf_inf");
      directed(0, 32'h7F80_0000, 32'h7F80_0000, R_COPY_A, 31'h7FC0_0000, "add_inf_inf");
      check("add_inf_sign_b", last_sb, 1'b0);
      directed(3, 32'h0000_0000, 32'h0000_0001, R_ZERO, 31'd0, "div_zero_by_sub");

      // Backpressure: four beats offered against a stalled sink.
      k = 0;
      out_before = n_out;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (k < 4);
         op = bp_op[k % 4]; a = bp_a[k % 4]; b = bp_b[k % 4];
         tick();
         if (last_accept) k++;
      end
      check("bp_accepts", k, 2);
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      @(negedge clk);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         in_valid = 1'b1;
         op = bp_op[k]; a = bp_a[k]; b = bp_b[k];
         tick();
         if (last_accept) k++;
      end
      drain();
      check("bp_out_count", n_out - out_before, 4);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         clr_flags = ($urandom_range(15) == 0);
         op = 2'($urandom_range(3));
         a  = pick_operand();
         b  = pick_operand();
         tick();
      end
      clr_flags = 1'b0;
      drain();

      // Reset with two beats in flight; first make sure a sticky flag is set.
      directed(0, 32'h7F80_0000, 32'hFF80_0000, R_INVALID, 31'd0, "pre_rst_invalid");
      check("pre_rst_flag_invalid", flag_invalid, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = 2'd3; a = 32'h3F80_0000; b = 32'h0000_0000;
      tick();
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_flag_invalid", flag_invalid, 1'b0);
      check("mid_rst_flag_divzero", flag_divzero, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      for (int c = 0; c < 4; c++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
